// File: rtl/ppu_reg_data.sv
// PPUDATA ($2007) engine: turns CPU port strobes into VRAM bus transactions, with the delayed read buffer and palette bypass.
// Optional macro PPU_DATA_TIMEOUT_EN aborts a transaction after TIMEOUT_CYCLES request cycles without vram_ack.
module ppu_reg_data #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_write_en,
  input  logic        data_read_en,
  input  logic [7:0]  cpu_data_in,
  output logic [7:0]  cpu_data_out,
  input  logic [15:0] address_in,
  output logic [13:0] vram_addr,
  output logic        vram_req,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  input  logic        vram_ack,
  input  logic [7:0]  palette_rdata,
  output logic        reg_data_write_completed,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_REQ = 2'd1,
    RD_REQ = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  read_buffer;
  logic        accept_wr;
  logic        accept_rd;
  logic        in_req;
  logic        palette_hit;
  logic        busy_strobe;
  logic        dropped_read;
  logic        timeout;
  logic [13:0] vram_addr_mirror;

  // Bits above the $4000 mirror carry no meaning for the VRAM bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address_in[15:14];

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  assign vram_addr_mirror = address_in[13:0];
  assign palette_hit      = (vram_addr_mirror[13:8] == 6'h3F);
  assign in_req           = (state == WR_REQ) || (state == RD_REQ);
  assign accept_wr        = (state == IDLE) && data_write_en;
  assign accept_rd        = (state == IDLE) && data_read_en && !data_write_en;
  // DONE counts as busy, so any strobe outside IDLE is dropped.
  assign busy_strobe      = (state != IDLE) && (data_write_en || data_read_en);
  assign dropped_read     = (state == IDLE) && data_write_en && data_read_en;

`ifdef PPU_DATA_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (accept_wr || accept_rd) begin
      tmo_cnt <= '0;
    end else if (in_req && !vram_ack) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // An ack arriving in the final allowed cycle still wins over the abort.
  assign timeout = in_req && !vram_ack && (tmo_cnt == TMO_LAST);
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept_wr) begin
          state_next = WR_REQ;
        end else if (accept_rd) begin
          state_next = RD_REQ;
        end
      end
      WR_REQ, RD_REQ: begin
        if (vram_ack || timeout) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state; reset forces IDLE so vram_req drops at once.
  always_comb begin
    vram_req                 = in_req;
    busy                     = (state != IDLE);
    reg_data_write_completed = (state == DONE);
  end

  // Transaction datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vram_addr    <= '0;
      vram_wdata   <= '0;
      vram_we      <= 1'b0;
      cpu_data_out <= '0;
      // NOTE: read_buffer is a single register, not a memory, so it is reset like any other flop.
      read_buffer  <= '0;
    end else begin
      if (accept_wr) begin
        vram_addr  <= vram_addr_mirror;
        vram_wdata <= cpu_data_in;
        vram_we    <= 1'b1;
      end else if (accept_rd) begin
        vram_we <= 1'b0;
        // Palette reads bypass the buffer and refill it from the nametable underneath.
        if (palette_hit) begin
          cpu_data_out <= palette_rdata;
          vram_addr    <= vram_addr_mirror & 14'h2FFF;
        end else begin
          cpu_data_out <= read_buffer;
          vram_addr    <= vram_addr_mirror;
        end
      end

      if (state == RD_REQ) begin
        if (vram_ack) begin
          read_buffer <= vram_rdata;
        end else if (timeout) begin
          read_buffer <= 8'h00;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (busy_strobe || dropped_read || timeout) begin
      overrun <= 1'b1;
    end
  end

  a_done_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
    (state == DONE) |=> (state == IDLE));
  a_no_pulse_with_req: assert property (@(posedge clk) disable iff (!rst_n)
    !(reg_data_write_completed && vram_req));

endmodule

// File: tb/tb_ppu_reg_data.sv
// Directed bench for ppu_reg_data with a small VRAM responder model and hand-computed expectations.
// Define PPU_DATA_TIMEOUT_EN for both files to exercise the request timeout.
module tb_ppu_reg_data;

  logic        clk;
  logic        rst_n;
  logic        data_write_en;
  logic        data_read_en;
  logic [7:0]  cpu_data_in;
  logic [7:0]  cpu_data_out;
  logic [15:0] address_in;
  logic [13:0] vram_addr;
  logic        vram_req;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
  logic        vram_ack;
  logic [7:0]  palette_rdata;
  logic        reg_data_write_completed;
  logic        busy;
  logic        overrun;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [0:16383];
  int ack_delay = 1;
  bit ack_block = 0;
  int req_cycles = 0;
  int txn_cnt = 0;
  int pulse_cnt = 0;

  ppu_reg_data #(.TIMEOUT_CYCLES(16)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .data_write_en            (data_write_en),
    .data_read_en             (data_read_en),
    .cpu_data_in              (cpu_data_in),
    .cpu_data_out             (cpu_data_out),
    .address_in               (address_in),
    .vram_addr                (vram_addr),
    .vram_req                 (vram_req),
    .vram_we                  (vram_we),
    .vram_wdata               (vram_wdata),
    .vram_rdata               (vram_rdata),
    .vram_ack                 (vram_ack),
    .palette_rdata            (palette_rdata),
    .reg_data_write_completed (reg_data_write_completed),
    .busy                     (busy),
    .overrun                  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM responder: acks ack_delay cycles after the request first appears.
  always @(negedge clk) begin
    if (!rst_n) begin
      vram_ack   = 1'b0;
      req_cycles = 0;
    end else if (vram_req && !ack_block) begin
      if (req_cycles == ack_delay) begin
        vram_ack   = 1'b1;
        vram_rdata = mem[vram_addr];
        if (vram_we) mem[vram_addr] = vram_wdata;
        txn_cnt++;
      end
      req_cycles++;
    end else begin
      vram_ack   = 1'b0;
      req_cycles = 0;
    end
    if (reg_data_write_completed) pulse_cnt++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
    address_in    = addr;
    cpu_data_in   = data;
    data_write_en = 1'b1;
    step();
    data_write_en = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] addr);
    address_in   = addr;
    data_read_en = 1'b1;
    step();
    data_read_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 64) begin
      step();
      n++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, want 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (vram_req !== 1'b0) begin n_err++; $display("FAIL rst_vram_req: got %b want 0", vram_req); end
    n_cmp++; if (vram_we !== 1'b0) begin n_err++; $display("FAIL rst_vram_we: got %b want 0", vram_we); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    n_cmp++; if (reg_data_write_completed !== 1'b0) begin n_err++; $display("FAIL rst_completed: got %b want 0", reg_data_write_completed); end
    n_cmp++; if (vram_addr !== 14'h0000) begin n_err++; $display("FAIL rst_vram_addr: got %h want 0000", vram_addr); end
    n_cmp++; if (vram_wdata !== 8'h00) begin n_err++; $display("FAIL rst_vram_wdata: got %h want 00", vram_wdata); end
    n_cmp++; if (cpu_data_out !== 8'h00) begin n_err++; $display("FAIL rst_cpu_data_out: got %h want 00", cpu_data_out); end
    n_cmp++; if (dut.read_buffer !== 8'h00) begin n_err++; $display("FAIL rst_read_buffer: got %h want 00", dut.read_buffer); end
  endtask

  task automatic test_write();
    int p0;
    p0 = pulse_cnt;
    do_write(16'h2005, 8'hA5);
    n_cmp++; if (vram_req !== 1'b1) begin n_err++; $display("FAIL wr_req: got %b want 1", vram_req); end
    n_cmp++; if (vram_addr !== 14'h2005) begin n_err++; $display("FAIL wr_addr: got %h want 2005", vram_addr); end
    n_cmp++; if (vram_we !== 1'b1) begin n_err++; $display("FAIL wr_we: got %b want 1", vram_we); end
    n_cmp++; if (vram_wdata !== 8'hA5) begin n_err++; $display("FAIL wr_wdata: got %h want a5", vram_wdata); end
    address_in = 16'h1234;
    step();
    n_cmp++; if (vram_addr !== 14'h2005) begin n_err++; $display("FAIL wr_addr_held: got %h want 2005", vram_addr); end
    n_cmp++; if (reg_data_write_completed !== 1'b0) begin n_err++; $display("FAIL wr_early_pulse: got %b want 0", reg_data_write_completed); end
    step();
    n_cmp++; if (reg_data_write_completed !== 1'b1) begin n_err++; $display("FAIL wr_pulse: got %b want 1", reg_data_write_completed); end
    n_cmp++; if (vram_req !== 1'b0) begin n_err++; $display("FAIL wr_req_drop: got %b want 0", vram_req); end
    step();
    n_cmp++; if (reg_data_write_completed !== 1'b0) begin n_err++; $display("FAIL wr_pulse_width: got %b want 0", reg_data_write_completed); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wr_busy_after: got %b want 0", busy); end
    n_cmp++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("FAIL wr_pulse_count: got %0d want 1", pulse_cnt - p0); end
    n_cmp++; if (mem[14'h2005] !== 8'hA5) begin n_err++; $display("FAIL wr_mem: got %h want a5", mem[14'h2005]); end
  endtask

  task automatic test_buffered_read();
    mem[14'h2000] = 8'h11;
    mem[14'h2001] = 8'h22;
    do_read(16'h2000);
    n_cmp++; if (cpu_data_out !== 8'h00) begin n_err++; $display("FAIL rd1_data: got %h want 00", cpu_data_out); end
    n_cmp++; if (vram_we !== 1'b0) begin n_err++; $display("FAIL rd1_we: got %b want 0", vram_we); end
    wait_idle("rd1");
    n_cmp++; if (dut.read_buffer !== 8'h11) begin n_err++; $display("FAIL rd1_buffer: got %h want 11", dut.read_buffer); end
    do_read(16'h2001);
    n_cmp++; if (cpu_data_out !== 8'h11) begin n_err++; $display("FAIL rd2_data: got %h want 11", cpu_data_out); end
    wait_idle("rd2");
    n_cmp++; if (dut.read_buffer !== 8'h22) begin n_err++; $display("FAIL rd2_buffer: got %h want 22", dut.read_buffer); end
    n_cmp++; if (cpu_data_out !== 8'h11) begin n_err++; $display("FAIL rd2_data_hold: got %h want 11", cpu_data_out); end
  endtask

  task automatic test_palette_read();
    mem[14'h2F01] = 8'h77;
    palette_rdata = 8'h2C;
    do_read(16'h3F01);
    palette_rdata = 8'h00;
    n_cmp++; if (cpu_data_out !== 8'h2C) begin n_err++; $display("FAIL pal_data: got %h want 2c", cpu_data_out); end
    n_cmp++; if (vram_addr !== 14'h2F01) begin n_err++; $display("FAIL pal_addr: got %h want 2f01", vram_addr); end
    wait_idle("pal");
    n_cmp++; if (dut.read_buffer !== 8'h77) begin n_err++; $display("FAIL pal_buffer: got %h want 77", dut.read_buffer); end
    n_cmp++; if (cpu_data_out !== 8'h2C) begin n_err++; $display("FAIL pal_data_hold: got %h want 2c", cpu_data_out); end
  endtask

  task automatic test_back_to_back();
    int p0, t0;
    p0 = pulse_cnt;
    t0 = txn_cnt;
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun_before: got %b want 0", overrun); end
    do_write(16'h0100, 8'h5A);
    do_read(16'h2001);
    wait_idle("b2b");
    step();
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL b2b_overrun: got %b want 1", overrun); end
    n_cmp++; if (txn_cnt - t0 !== 1) begin n_err++; $display("FAIL b2b_txn_count: got %0d want 1", txn_cnt - t0); end
    n_cmp++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("FAIL b2b_pulse_count: got %0d want 1", pulse_cnt - p0); end
    n_cmp++; if (cpu_data_out !== 8'h2C) begin n_err++; $display("FAIL b2b_data_hold: got %h want 2c", cpu_data_out); end
    n_cmp++; if (mem[14'h0100] !== 8'h5A) begin n_err++; $display("FAIL b2b_mem: got %h want 5a", mem[14'h0100]); end
  endtask

  task automatic test_reset_mid();
    int p0;
    p0 = pulse_cnt;
    ack_block = 1'b1;
    do_read(16'h2000);
    step();
    step();
    n_cmp++; if (vram_req !== 1'b1) begin n_err++; $display("FAIL rmid_req_held: got %b want 1", vram_req); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (vram_req !== 1'b0) begin n_err++; $display("FAIL rmid_req: got %b want 0", vram_req); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_cmp++; if (cpu_data_out !== 8'h00) begin n_err++; $display("FAIL rmid_data: got %h want 00", cpu_data_out); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rmid_overrun: got %b want 0", overrun); end
    step();
    step();
    rst_n     = 1'b1;
    ack_block = 1'b0;
    step();
    step();
    step();
    n_cmp++; if (pulse_cnt - p0 !== 0) begin n_err++; $display("FAIL rmid_pulse: got %0d want 0", pulse_cnt - p0); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    int p0, cnt;
    do_read(16'h2001);
    wait_idle("tmo_prep");
    n_cmp++; if (dut.read_buffer !== 8'h22) begin n_err++; $display("FAIL tmo_prep_buffer: got %h want 22", dut.read_buffer); end
    p0 = pulse_cnt;
    cnt = 0;
    ack_block = 1'b1;
`ifdef PPU_DATA_TIMEOUT_EN
    do_read(16'h2001);
    while (vram_req && cnt < 64) begin
      cnt++;
      step();
    end
    n_cmp++; if (cnt !== 16) begin n_err++; $display("FAIL tmo_req_cycles: got %0d want 16", cnt); end
    n_cmp++; if (reg_data_write_completed !== 1'b1) begin n_err++; $display("FAIL tmo_pulse: got %b want 1", reg_data_write_completed); end
    wait_idle("tmo");
    n_cmp++; if (dut.read_buffer !== 8'h00) begin n_err++; $display("FAIL tmo_buffer: got %h want 00", dut.read_buffer); end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL tmo_overrun: got %b want 1", overrun); end
    ack_block = 1'b0;
`else
    do_read(16'h2000);
    for (int i = 0; i < 40; i++) begin
      if (vram_req) cnt++;
      step();
    end
    n_cmp++; if (cnt !== 40) begin n_err++; $display("FAIL notmo_req_held: got %0d want 40", cnt); end
    ack_block = 1'b0;
    wait_idle("notmo");
    n_cmp++; if (dut.read_buffer !== 8'h11) begin n_err++; $display("FAIL notmo_buffer: got %h want 11", dut.read_buffer); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL notmo_overrun: got %b want 0", overrun); end
`endif
    n_cmp++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("FAIL tmo_pulse_count: got %0d want 1", pulse_cnt - p0); end
  endtask

  task automatic test_same_cycle();
    int p0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    p0 = pulse_cnt;
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL both_overrun_before: got %b want 0", overrun); end
    address_in    = 16'h0200;
    cpu_data_in   = 8'h3C;
    data_write_en = 1'b1;
    data_read_en  = 1'b1;
    step();
    data_write_en = 1'b0;
    data_read_en  = 1'b0;
    n_cmp++; if (vram_we !== 1'b1) begin n_err++; $display("FAIL both_we: got %b want 1", vram_we); end
    n_cmp++; if (vram_wdata !== 8'h3C) begin n_err++; $display("FAIL both_wdata: got %h want 3c", vram_wdata); end
    wait_idle("both");
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL both_overrun: got %b want 1", overrun); end
    n_cmp++; if (mem[14'h0200] !== 8'h3C) begin n_err++; $display("FAIL both_mem: got %h want 3c", mem[14'h0200]); end
    n_cmp++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("FAIL both_pulse_count: got %0d want 1", pulse_cnt - p0); end
    n_cmp++; if (dut.read_buffer !== 8'h00) begin n_err++; $display("FAIL both_buffer: got %h want 00", dut.read_buffer); end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    rst_n         = 1'b0;
    data_write_en = 1'b0;
    data_read_en  = 1'b0;
    cpu_data_in   = 8'h00;
    address_in    = 16'h0000;
    palette_rdata = 8'h00;
    vram_rdata    = 8'h00;
    vram_ack      = 1'b0;
    step();
    step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_write();
    test_buffered_read();
    test_palette_read();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_same_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ppu_reg_data.md
Name: ppu_reg_data

Overview:
- PPUDATA port ($2007) engine. It sits directly downstream of the PPU address register.
- It converts CPU reads and writes of $2007 into VRAM bus transactions at the current VRAM address.
- It implements the one-deep delayed read buffer and the palette read bypass.
- It returns a one-cycle completion pulse that drives the address register's post-access increment (+1 or +32).

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles to wait for vram_ack before aborting. Used only with PPU_DATA_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_write_en  in  1  one-cycle CPU write strobe to $2007.
- data_read_en  in  1  one-cycle CPU read strobe of $2007.
- cpu_data_in  in  8  CPU write data.
- cpu_data_out  out  8  registered CPU read data.
- address_in  in  16  current VRAM address from the address register.
- vram_addr  out  14  VRAM transaction address.
- vram_req  out  1  transaction request; held high until acknowledged.
- vram_we  out  1  1 = write, 0 = read; valid while vram_req is high.
- vram_wdata  out  8  write data; valid while vram_req is high.
- vram_rdata  in  8  read data; sampled in the cycle where vram_ack is high.
- vram_ack  in  1  transaction complete; only meaningful while vram_req is high.
- palette_rdata  in  8  combinational palette RAM data for address_in.
- reg_data_write_completed  out  1  one-cycle pulse on completion of any read or write access; feeds the address register increment.
- busy  out  1  high whenever state != IDLE.
- overrun  out  1  sticky flag; a strobe arrived while busy.

Behaviour:
- Reset: the asynchronous reset takes effect immediately.
  - State goes to IDLE.
  - vram_req, vram_we, reg_data_write_completed, busy and overrun are 0.
  - vram_addr, vram_wdata, cpu_data_out and read_buffer are 0.
  - Reset mid-transaction drops vram_req immediately with no completion pulse; any in-flight ack is ignored.
- Address: at strobe acceptance, vram_addr <= address_in[13:0] (the $4000 mirror). It is latched and held for the whole transaction, so later address_in changes have no effect.
- Palette range: latched addr[13:8] == 6'h3F.
- FSM states: IDLE, WR_REQ, RD_REQ, DONE.
- IDLE + data_write_en:
  - Latch the address and vram_wdata <= cpu_data_in.
  - vram_we <= 1 and vram_req <= 1.
  - Go to WR_REQ.
- IDLE + data_read_en (and no write):
  - cpu_data_out <= palette range ? palette_rdata : read_buffer.
  - vram_we <= 0 and vram_req <= 1.
  - Go to RD_REQ.
  - The fetch address is the latched address, except in palette range, where it is the latched address & 14'h2FFF (the underlying nametable mirror).
- Both strobes in the same cycle: the write is accepted, the read is dropped, and overrun is set.
- WR_REQ: wait for vram_ack, then vram_req <= 0 and go to DONE.
- RD_REQ: wait for vram_ack, then read_buffer <= vram_rdata, vram_req <= 0, and go to DONE.
- DONE: reg_data_write_completed = 1 for exactly this one cycle, then go to IDLE.
- A strobe in the DONE cycle is treated as a busy strobe (below).
- Strobe while busy: ignored, no transaction, overrun <= 1. overrun clears only on reset.
- Latency with ack in the first request cycle:
  - Strobe sampled at edge N.
  - vram_req high in cycle N+1.
  - DONE in cycle N+2.
  - Back in IDLE at N+3.
  - Minimum spacing between accepted strobes is therefore 3 cycles.
- cpu_data_out is valid from cycle N+1 and holds until the next accepted read.
- Read semantics: a read returns the buffer value loaded by the previous read (one-read delay). Palette addresses return palette data directly, and the buffer is refilled with the nametable data underneath.
- Writes never modify read_buffer.
- busy is combinationally derived from state.

Optional Feature:
- Macro PPU_DATA_TIMEOUT_EN.
- When defined: a counter runs in WR_REQ/RD_REQ. If vram_ack has not arrived after TIMEOUT_CYCLES request cycles:
  - vram_req drops and the FSM goes to DONE, so the completion pulse still fires.
  - read_buffer loads 8'h00 on a read timeout.
  - overrun is set.
- When undefined: there is no counter, and the FSM waits indefinitely for vram_ack.

Test Plan:
- Write with address_in = 16'h2005, cpu_data_in = 8'hA5, ack one cycle after req:
  - vram_addr = 14'h2005, vram_we = 1, vram_wdata = 8'hA5.
  - Exactly one reg_data_write_completed pulse, 1 cycle after ack.
- Two reads at 14'h2000 with VRAM holding 8'h11 then 8'h22 at consecutive addresses (address_in increments between them):
  - First read returns 8'h00 (buffer after reset).
  - Second read returns 8'h11; read_buffer = 8'h22 afterward.
- Read with address_in = 16'h3F01, palette_rdata = 8'h2C, VRAM[14'h2F01] = 8'h77:
  - cpu_data_out = 8'h2C.
  - vram_addr = 14'h2F01; read_buffer = 8'h77.
- Write strobe, then a read strobe 1 cycle later (busy):
  - The read is ignored and overrun = 1.
  - Only one VRAM transaction and one completion pulse occur.
- Assert rst_n = 0 while in RD_REQ with ack withheld:
  - vram_req = 0 immediately; no completion pulse.
  - cpu_data_out = 8'h00 and busy = 0.
- With PPU_DATA_TIMEOUT_EN, TIMEOUT_CYCLES = 16, ack never asserted:
  - Request drops after 16 cycles and the completion pulse fires.
  - read_buffer = 8'h00 and overrun = 1.
